// File: rtl/prog_sequencer_pkg.sv
// Shared definitions for the run-control sequencer: FSM encoding and default widths.
package prog_sequencer_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_ARM  = 2'd1,
    SEQ_RUN  = 2'd2,
    SEQ_DONE = 2'd3
  } seq_state_t;

  localparam int unsigned SEQ_PC_W_DEF  = 10;
  localparam int unsigned SEQ_CNT_W_DEF = 16;

endpackage

// File: rtl/prog_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Clr,
  input  logic         Inc,
  output logic [W-1:0] Q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (Clr) begin
      cnt_d = '0;
    end else if (Inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign Q = cnt_q;

endmodule

// File: rtl/prog_sequencer.sv
// Run-control sequencer: owns the PC, the Start/Done handshake, retire/cycle counters and watchdog.
module prog_sequencer
  import prog_sequencer_pkg::*;
#(
  parameter int unsigned PC_W       = SEQ_PC_W_DEF,
  parameter int unsigned CNT_W      = SEQ_CNT_W_DEF,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned MAX_CYCLES = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Ack_In,
  input  logic             Jmp_Flag,
  input  logic             Beq_Flag,
  input  logic [PC_W-1:0]  Target,
  input  logic             Stall,
  output logic [PC_W-1:0]  PC,
  output logic             Run_En,
  output logic             Done,
  output logic             Timeout,
  output logic [CNT_W-1:0] Cycle_Count,
  output logic [CNT_W-1:0] Instr_Count
);

  localparam logic [PC_W-1:0]  START_PC = PC_W'(START_ADDR);
  localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(MAX_CYCLES);
  localparam logic             WD_EN    = (MAX_CYCLES != 0);

  seq_state_t       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             run_en_q, run_en_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;

  logic             cnt_clr;
  logic             cyc_inc;
  logic             ins_inc;
  logic             wd_hit;
  logic             hlt_retire;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instr_cnt;

  // Next-state, PC mux and counter controls
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    timeout_d  = timeout_q;
    cyc_inc    = 1'b0;
    ins_inc    = 1'b0;
    wd_hit     = 1'b0;
    hlt_retire = 1'b0;

    case (state_q)
      SEQ_IDLE: begin
        if (Start) state_d = SEQ_ARM;
      end
      SEQ_ARM: begin
        if (!Start) state_d = SEQ_RUN;
      end
      SEQ_RUN: begin
        if (Start) begin
          state_d = SEQ_ARM;
        end else begin
          cyc_inc    = 1'b1;
          hlt_retire = Ack_In && !Stall;
          wd_hit     = WD_EN && (cycle_cnt != '1) &&
                       ((cycle_cnt + CNT_W'(1)) == WD_LIMIT);
          if (!Stall) begin
            ins_inc = 1'b1;
            if (Ack_In) begin
              state_d = SEQ_DONE;
            end else if (Jmp_Flag || Beq_Flag) begin
              pc_d = Target;
            end else begin
              pc_d = pc_q + PC_W'(1);
            end
          end
          // An HLT retiring in the limit cycle wins over the watchdog
          if (wd_hit && !hlt_retire) begin
            state_d   = SEQ_DONE;
            timeout_d = 1'b1;
          end
        end
      end
      SEQ_DONE: begin
        if (Start) state_d = SEQ_ARM;
      end
      default: state_d = SEQ_IDLE;
    endcase

    // Arming (from any state) re-initialises PC and status
    if (state_d == SEQ_ARM) begin
      pc_d      = START_PC;
      timeout_d = 1'b0;
    end

    cnt_clr  = (state_d == SEQ_ARM);
    run_en_d = (state_d == SEQ_RUN);
    done_d   = (state_d == SEQ_DONE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= SEQ_IDLE;
      pc_q      <= START_PC;
      run_en_q  <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      run_en_q  <= run_en_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .Clr   (cnt_clr),
    .Inc   (cyc_inc),
    .Q     (cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .Clr   (cnt_clr),
    .Inc   (ins_inc),
    .Q     (instr_cnt)
  );

  assign PC          = pc_q;
  assign Run_En      = run_en_q;
  assign Done        = done_q;
  assign Timeout     = timeout_q;
  assign Cycle_Count = cycle_cnt;
  assign Instr_Count = instr_cnt;

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: vector table through a scoreboard, plus watchdog/wrap/reset sequences.
module tb_prog_sequencer;

  typedef struct {
    logic        rst, start, ack, jmp, beq, stall;
    logic [9:0]  tgt;
    logic [9:0]  pc;
    logic        run, done, to;
    logic [15:0] cyc, ins;
  } vec_t;

  logic        Clk = 1'b0;
  logic        Reset, Start, Ack_In, Jmp_Flag, Beq_Flag, Stall;
  logic [9:0]  Target;
  logic [9:0]  pc, wd_pc;
  logic        run_en, done, timeout, wd_run_en, wd_done, wd_timeout;
  logic [15:0] cyc, ins, wd_cyc, wd_ins;

  int n_checks = 0;
  int n_fail   = 0;
  int vec_no   = 0;
  vec_t tbl[$];
  vec_t sb[$];

  always #5 Clk = ~Clk;

  prog_sequencer #(.PC_W(10), .CNT_W(16), .START_ADDR(0), .MAX_CYCLES(0)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack_In(Ack_In), .Jmp_Flag(Jmp_Flag),
    .Beq_Flag(Beq_Flag), .Target(Target), .Stall(Stall), .PC(pc), .Run_En(run_en),
    .Done(done), .Timeout(timeout), .Cycle_Count(cyc), .Instr_Count(ins)
  );

  prog_sequencer #(.PC_W(10), .CNT_W(16), .START_ADDR(0), .MAX_CYCLES(20)) dut_wd (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack_In(Ack_In), .Jmp_Flag(Jmp_Flag),
    .Beq_Flag(Beq_Flag), .Target(Target), .Stall(Stall), .PC(wd_pc), .Run_En(wd_run_en),
    .Done(wd_done), .Timeout(wd_timeout), .Cycle_Count(wd_cyc), .Instr_Count(wd_ins)
  );

  function automatic vec_t mk(input logic rst, start, ack, jmp, beq, stall,
                              input logic [9:0] tgt, input logic [9:0] epc,
                              input logic erun, edone, eto, input logic [15:0] ecyc, eins);
    vec_t v;
    v.rst = rst; v.start = start; v.ack = ack; v.jmp = jmp; v.beq = beq; v.stall = stall;
    v.tgt = tgt; v.pc = epc; v.run = erun; v.done = edone; v.to = eto;
    v.cyc = ecyc; v.ins = eins;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, start, ack, jmp, beq, stall, input logic [9:0] tgt);
    Reset = rst; Start = start; Ack_In = ack; Jmp_Flag = jmp; Beq_Flag = beq;
    Stall = stall; Target = tgt;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Drive one vector, queue its expectation, compare after the edge
  task automatic step(input vec_t v);
    vec_t e;
    drive(v.rst, v.start, v.ack, v.jmp, v.beq, v.stall, v.tgt);
    sb.push_back(v);
    tick();
    e = sb.pop_front();
    check($sformatf("v%0d pc", vec_no),      32'(pc),      32'(e.pc));
    check($sformatf("v%0d run_en", vec_no),  32'(run_en),  32'(e.run));
    check($sformatf("v%0d done", vec_no),    32'(done),    32'(e.done));
    check($sformatf("v%0d timeout", vec_no), 32'(timeout), 32'(e.to));
    check($sformatf("v%0d cycles", vec_no),  32'(cyc),     32'(e.cyc));
    check($sformatf("v%0d instrs", vec_no),  32'(ins),     32'(e.ins));
    vec_no++;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0);

    // rst st ack jmp beq stl tgt      pc      run dn to cyc ins
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 1, 0, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 10'h000, 10'h000, 1, 0, 0, 0, 0));
    for (int k = 1; k <= 5; k++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 10'h000, 10'(k), 1, 0, 0, 16'(k), 16'(k)));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 10'h040, 10'h040, 1, 0, 0, 6, 6));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 10'h000, 10'h041, 1, 0, 0, 7, 7));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 10'h010, 10'h010, 1, 0, 0, 8, 8));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 10'h007, 10'h007, 1, 0, 0, 9, 9));
    tbl.push_back(mk(0, 0, 1, 1, 0, 1, 10'h123, 10'h007, 1, 0, 0, 10, 9));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 10'h000, 10'h007, 1, 0, 0, 11, 9));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 10'h000, 10'h008, 1, 0, 0, 12, 10));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 10'h000, 10'h009, 1, 0, 0, 13, 11));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 10'h000, 10'h009, 0, 1, 0, 14, 12));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 10'h000, 10'h009, 0, 1, 0, 14, 12));
    tbl.push_back(mk(0, 0, 1, 1, 0, 1, 10'h100, 10'h009, 0, 1, 0, 14, 12));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 10'h000, 10'h000, 1, 0, 0, 0, 0));
    for (int k = 1; k <= 9; k++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 10'h000, 10'(k), 1, 0, 0, 16'(k), 16'(k)));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 10'h000, 10'h009, 0, 1, 0, 10, 10));

    foreach (tbl[i]) step(tbl[i]);

    // Watchdog at 20 RUN cycles; the MAX_CYCLES=0 instance keeps running
    drive(1, 0, 0, 0, 0, 0, 10'h0); tick();
    drive(0, 1, 0, 0, 0, 0, 10'h0); tick();
    drive(0, 0, 0, 0, 0, 0, 10'h0); tick();
    check("wd run after arm", 32'(wd_run_en), 32'd1);
    for (int i = 0; i < 19; i++) tick();
    check("wd done before limit", 32'(wd_done), 32'd0);
    check("wd cycles before limit", 32'(wd_cyc), 32'd19);
    tick();
    check("wd done at limit", 32'(wd_done), 32'd1);
    check("wd timeout at limit", 32'(wd_timeout), 32'd1);
    check("wd cycles at limit", 32'(wd_cyc), 32'd20);
    check("wd run_en at limit", 32'(wd_run_en), 32'd0);
    check("nowd still running", 32'(run_en), 32'd1);
    check("nowd done", 32'(done), 32'd0);
    check("nowd cycles", 32'(cyc), 32'd20);
    tick();
    check("wd cycles hold", 32'(wd_cyc), 32'd20);
    check("wd timeout hold", 32'(wd_timeout), 32'd1);
    drive(0, 1, 0, 0, 0, 0, 10'h0); tick();
    check("wd rearm done", 32'(wd_done), 32'd0);
    check("wd rearm timeout", 32'(wd_timeout), 32'd0);
    check("wd rearm cycles", 32'(wd_cyc), 32'd0);
    check("wd rearm instrs", 32'(wd_ins), 32'd0);

    // HLT in the limit cycle beats the watchdog
    drive(0, 0, 0, 0, 0, 0, 10'h0); tick();
    for (int i = 0; i < 19; i++) tick();
    drive(0, 0, 1, 0, 0, 0, 10'h0); tick();
    check("wd+ack done", 32'(wd_done), 32'd1);
    check("wd+ack timeout", 32'(wd_timeout), 32'd0);
    check("wd+ack instrs", 32'(wd_ins), 32'd20);

    // PC wrap, then reset in the middle of RUN
    vec_no = 100;
    step(mk(1, 0, 0, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0, 0, 0));
    step(mk(0, 1, 0, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 10'h000, 10'h000, 1, 0, 0, 0, 0));
    step(mk(0, 0, 0, 1, 0, 0, 10'h3FF, 10'h3FF, 1, 0, 0, 1, 1));
    step(mk(0, 0, 0, 0, 0, 0, 10'h000, 10'h000, 1, 0, 0, 2, 2));
    step(mk(0, 0, 0, 1, 0, 0, 10'h3FF, 10'h3FF, 1, 0, 0, 3, 3));
    step(mk(1, 0, 0, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0, 0, 0));
    step(mk(0, 0, 1, 1, 0, 0, 10'h155, 10'h000, 0, 0, 0, 0, 0));
    // Start in RUN aborts back to ARM without raising Done
    step(mk(0, 1, 0, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 10'h000, 10'h000, 1, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 10'h000, 10'h001, 1, 0, 0, 1, 1));
    step(mk(0, 1, 1, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
